// File: rtl/cvxif_result_scheduler_if.sv
// ALU-result, commit and CV-X-IF result signals for the result scheduler.
// "slave" is the scheduler side; "master" is the ALU/CPU side.
interface cvxif_result_scheduler_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartIdWidth = 1
);
  logic                   alu_valid_i;
  logic [HartIdWidth-1:0] alu_hartid_i;
  logic [IdWidth-1:0]     alu_id_i;
  logic [XLEN-1:0]        alu_data_i;
  logic [4:0]             alu_rd_i;
  logic                   alu_we_i;
  logic                   alu_ready_o;

  logic                   commit_valid_i;
  logic [IdWidth-1:0]     commit_id_i;
  logic                   commit_kill_i;

  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [HartIdWidth-1:0] result_hartid_o;
  logic [IdWidth-1:0]     result_id_o;
  logic [XLEN-1:0]        result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;
  logic                   overflow_o;

  modport slave (
    input  alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
    output alu_ready_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output result_valid_o,
    input  result_ready_i,
    output result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    output overflow_o
  );

  modport master (
    output alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
    input  alu_ready_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  result_valid_o,
    output result_ready_i,
    input  result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    input  overflow_o
  );
endinterface

// File: rtl/cvxif_result_scheduler.sv
// In-order result FIFO gated by a per-id commit/kill table; committed heads are
// offered on the CV-X-IF result port, killed heads are dropped.
module cvxif_result_scheduler #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartIdWidth = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cvxif_result_scheduler_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NumIds = 2 ** IdWidth;

  typedef struct packed {
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [XLEN-1:0]        data;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  entry_t            mem [Depth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic [NumIds-1:0] cm, kl;
  logic              overflow_q;

  entry_t head, out_e;
  logic   empty, full, push, pop, head_cm, head_kl, commit_ok;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign push    = bus.alu_valid_i && !full;
  assign head    = mem[rd_ptr];
  assign head_cm = cm[head.id];
  assign head_kl = kl[head.id];
  // A killed head drains without waiting for result_ready.
  assign pop     = !empty && (head_kl || (head_cm && bus.result_ready_i));
  // First commit/kill for an id wins; repeats are ignored until the id retires.
  assign commit_ok = bus.commit_valid_i && !cm[bus.commit_id_i] && !kl[bus.commit_id_i];
  assign out_e   = empty ? '0 : head;

  assign bus.alu_ready_o     = !full;
  assign bus.result_valid_o  = !empty && head_cm;
  assign bus.result_hartid_o = out_e.hartid;
  assign bus.result_id_o     = out_e.id;
  assign bus.result_data_o   = out_e.data;
  assign bus.result_rd_o     = out_e.rd;
  assign bus.result_we_o     = out_e.we;
  assign bus.overflow_o      = overflow_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{hartid: bus.alu_hartid_i, id: bus.alu_id_i,
                               data: bus.alu_data_i, rd: bus.alu_rd_i, we: bus.alu_we_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cm         <= '0;
      kl         <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (bus.alu_valid_i && full) overflow_q <= 1'b1;
      if (commit_ok) begin
        if (bus.commit_kill_i) kl[bus.commit_id_i] <= 1'b1;
        else                   cm[bus.commit_id_i] <= 1'b1;
      end
      // Retiring clear is ordered last so it beats a same-cycle commit.
      if (pop) begin
        cm[head.id] <= 1'b0;
        kl[head.id] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cvxif_result_scheduler.sv
// Directed bench for cvxif_result_scheduler: commit orders, back-pressure, kill,
// overflow, streaming and mid-operation reset.
module tb_cvxif_result_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cvxif_result_scheduler_if #(.XLEN(32), .IdWidth(4), .HartIdWidth(1)) bus ();

  cvxif_result_scheduler #(.Depth(4), .XLEN(32), .IdWidth(4), .HartIdWidth(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [3:0] id, input logic [31:0] data,
                     input logic [4:0] rd, input logic we);
    bus.alu_valid_i  = v;
    bus.alu_hartid_i = 1'b0;
    bus.alu_id_i     = id;
    bus.alu_data_i   = data;
    bus.alu_rd_i     = rd;
    bus.alu_we_i     = we;
  endtask

  task automatic cmt(input logic v, input logic [3:0] id, input logic kill);
    bus.commit_valid_i = v;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
  endtask

  initial begin
    rst = 1'b1;
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    cmt(1'b0, 4'd0, 1'b0);
    bus.result_ready_i = 1'b0;
    cyc(); cyc();
    chk("rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("rst_valid",     32'(bus.result_valid_o), 32'd0);
    chk("rst_overflow",  32'(bus.overflow_o), 32'd0);
    chk("rst_data",      bus.result_data_o, 32'h0);
    chk("rst_id",        32'(bus.result_id_o), 32'd0);
    rst = 1'b0;

    // Commit-first: commit id3 at c0, push at c2, result at c3, empty at c4
    bus.result_ready_i = 1'b1;
    cmt(1'b1, 4'd3, 1'b0);
    cyc();
    cmt(1'b0, 4'd0, 1'b0);
    cyc();
    chk("cf_c2_valid", 32'(bus.result_valid_o), 32'd0);
    alu(1'b1, 4'd3, 32'hDEADBEEF, 5'd5, 1'b1);
    cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    chk("cf_c3_valid", 32'(bus.result_valid_o), 32'd1);
    chk("cf_c3_data",  bus.result_data_o, 32'hDEADBEEF);
    chk("cf_c3_rd",    32'(bus.result_rd_o), 32'd5);
    chk("cf_c3_id",    32'(bus.result_id_o), 32'd3);
    chk("cf_c3_we",    32'(bus.result_we_o), 32'd1);
    cyc();
    chk("cf_c4_valid", 32'(bus.result_valid_o), 32'd0);
    chk("cf_c4_count", 32'(dut.count), 32'd0);
    chk("cf_c4_cm3",   32'(dut.cm[3]), 32'd0);

    // Result-first with back-pressure: push id1 at c0, commit at c3, ready at c7
    bus.result_ready_i = 1'b0;
    alu(1'b1, 4'd1, 32'h11112222, 5'd7, 1'b0);
    cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    cyc(); cyc();
    chk("rf_c3_valid", 32'(bus.result_valid_o), 32'd0);
    cmt(1'b1, 4'd1, 1'b0);
    cyc();
    cmt(1'b0, 4'd0, 1'b0);
    for (int c = 4; c <= 7; c++) begin
      if (c == 7) bus.result_ready_i = 1'b1;
      chk($sformatf("rf_c%0d_valid", c), 32'(bus.result_valid_o), 32'd1);
      chk($sformatf("rf_c%0d_data", c),  bus.result_data_o, 32'h11112222);
      chk($sformatf("rf_c%0d_rd", c),    32'(bus.result_rd_o), 32'd7);
      cyc();
    end
    chk("rf_c8_valid", 32'(bus.result_valid_o), 32'd0);

    // Kill: push ids 0,1,2 then commit 0, kill 1, commit 2
    alu(1'b1, 4'd0, 32'hA0, 5'd1, 1'b1); cyc();
    alu(1'b1, 4'd1, 32'hA1, 5'd2, 1'b1); cyc();
    alu(1'b1, 4'd2, 32'hA2, 5'd3, 1'b1); cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    chk("kl_uncommitted_valid", 32'(bus.result_valid_o), 32'd0);
    cmt(1'b1, 4'd0, 1'b0); cyc();
    chk("kl_a1_valid", 32'(bus.result_valid_o), 32'd1);
    chk("kl_a1_id",    32'(bus.result_id_o), 32'd0);
    chk("kl_a1_data",  bus.result_data_o, 32'hA0);
    cmt(1'b1, 4'd1, 1'b1); cyc();
    chk("kl_a2_valid", 32'(bus.result_valid_o), 32'd0);
    cmt(1'b1, 4'd2, 1'b0); cyc();
    cmt(1'b0, 4'd0, 1'b0);
    chk("kl_a3_valid", 32'(bus.result_valid_o), 32'd1);
    chk("kl_a3_id",    32'(bus.result_id_o), 32'd2);
    chk("kl_a3_data",  bus.result_data_o, 32'hA2);
    cyc();
    chk("kl_a4_valid", 32'(bus.result_valid_o), 32'd0);
    chk("kl_a4_count", 32'(dut.count), 32'd0);
    chk("kl_id1_bits", 32'({dut.cm[1], dut.kl[1]}), 32'd0);

    // Full/overflow: four uncommitted pushes, then a fifth
    for (int i = 0; i < 4; i++) begin
      alu(1'b1, 4'(4 + i), 32'h40 + 32'(i), 5'(10 + i), 1'b1);
      cyc();
    end
    chk("ov_full_ready", 32'(bus.alu_ready_o), 32'd0);
    chk("ov_full_count", 32'(dut.count), 32'd4);
    chk("ov_pre_flag",   32'(bus.overflow_o), 32'd0);
    alu(1'b1, 4'd8, 32'h99, 5'd31, 1'b1);
    cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    chk("ov_flag",  32'(bus.overflow_o), 32'd1);
    chk("ov_count", 32'(dut.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cmt(1'b1, 4'(4 + i), 1'b0);
      cyc();
      chk($sformatf("ov_out%0d_valid", i), 32'(bus.result_valid_o), 32'd1);
      chk($sformatf("ov_out%0d_id", i),    32'(bus.result_id_o), 32'(4 + i));
      chk($sformatf("ov_out%0d_data", i),  bus.result_data_o, 32'h40 + 32'(i));
    end
    cmt(1'b0, 4'd0, 1'b0);
    cyc();
    chk("ov_drain_valid", 32'(bus.result_valid_o), 32'd0);
    chk("ov_drain_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("ov_sticky",      32'(bus.overflow_o), 32'd1);

    // Streaming: push + commit of the same id every cycle
    for (int k = 0; k < 16; k++) begin
      alu(1'b1, 4'(k), 32'h1000 + 32'(k), 5'(k), k[0]);
      cmt(1'b1, 4'(k), 1'b0);
      cyc();
      chk($sformatf("st%0d_valid", k), 32'(bus.result_valid_o), 32'd1);
      chk($sformatf("st%0d_id", k),    32'(bus.result_id_o), 32'(k));
      chk($sformatf("st%0d_data", k),  bus.result_data_o, 32'h1000 + 32'(k));
      chk($sformatf("st%0d_count", k), 32'(dut.count), 32'd1);
    end
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    cmt(1'b0, 4'd0, 1'b0);
    cyc();
    chk("st_end_valid", 32'(bus.result_valid_o), 32'd0);
    chk("st_end_count", 32'(dut.count), 32'd0);

    // Reset mid-operation: 3 buffered, 2 committed, CPU stalled
    bus.result_ready_i = 1'b0;
    alu(1'b1, 4'd9,  32'hB9, 5'd9,  1'b1); cyc();
    alu(1'b1, 4'd10, 32'hBA, 5'd10, 1'b1); cyc();
    alu(1'b1, 4'd11, 32'hBB, 5'd11, 1'b1); cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    cmt(1'b1, 4'd9, 1'b0); cyc();
    cmt(1'b1, 4'd10, 1'b0); cyc();
    cmt(1'b0, 4'd0, 1'b0);
    chk("rs_pre_valid", 32'(bus.result_valid_o), 32'd1);
    chk("rs_pre_id",    32'(bus.result_id_o), 32'd9);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rs_valid",    32'(bus.result_valid_o), 32'd0);
    chk("rs_ready",    32'(bus.alu_ready_o), 32'd1);
    chk("rs_overflow", 32'(bus.overflow_o), 32'd0);
    chk("rs_count",    32'(dut.count), 32'd0);
    bus.result_ready_i = 1'b1;
    alu(1'b1, 4'd0, 32'hC0, 5'd1, 1'b1);
    cyc();
    alu(1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rs_post%0d_valid", i), 32'(bus.result_valid_o), 32'd0);
      cyc();
    end
    chk("rs_post_count", 32'(dut.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cvxif_result_scheduler.md
# cvxif_result_scheduler

Sits between the coprocessor ALU and the CV-X-IF result interface. It buffers ALU results in an in-order FIFO and holds each one until the CPU's commit interface says whether that instruction retires or is killed. Committed results are presented with a proper valid/ready handshake; killed results are silently discarded. Its `alu_ready_o` back-pressures instruction issue, so the ALU output is never lost while the CPU stalls `result_ready`.

## Interface
Parameters:
- `Depth`, 4 — FIFO entries; power of two, ≥2.
- `XLEN`, 32 — result data width.
- `IdWidth`, 4 — instruction id width; commit table has 2^IdWidth entries.
- `HartIdWidth`, 1 — hart id width.

Ports:
- `clk_i`  in  1  — clock; all state updates on rising edge.
- `rst_i`  in  1  — reset, synchronous, active-high.
- `alu_valid_i`  in  1  — ALU result valid (single-cycle pulse per instruction).
- `alu_hartid_i`  in  HartIdWidth  — hart of result.
- `alu_id_i`  in  IdWidth  — instruction id of result.
- `alu_data_i`  in  XLEN  — result data.
- `alu_rd_i`  in  5  — destination register.
- `alu_we_i`  in  1  — register write enable.
- `alu_ready_o`  out  1  — FIFO not full; gates coprocessor `issue_ready`.
- `commit_valid_i`  in  1  — commit transaction valid.
- `commit_id_i`  in  IdWidth  — id being committed or killed.
- `commit_kill_i`  in  1  — 1 = kill, 0 = commit.
- `result_valid_o`  out  1  — result offered to CPU.
- `result_ready_i`  in  1  — CPU accepts result.
- `result_hartid_o`, `result_id_o`, `result_data_o`, `result_rd_o`, `result_we_o`  out  widths as ALU inputs  — head entry fields.
- `overflow_o`  out  1  — sticky: push attempted while full.

## Operation
- FIFO of `Depth` entries {hartid, id, data, rd, we}, with wr_ptr, rd_ptr and count (log2(Depth)+1 bits). Pointers wrap modulo `Depth`.
- Push: `alu_valid_i` && `alu_ready_o`.
- Push while full: the entry is dropped, `overflow_o` is set, and FIFO state is unchanged.
- Commit table: per id, bits `cm` (commit seen) and `kl` (kill seen).
  - `commit_valid_i` sets `cm` (kill=0) or `kl` (kill=1) for `commit_id_i`.
  - A commit is ignored if `cm` or `kl` is already set for that id.
- Head evaluation uses registered table bits for the head id. FIFO empty → `result_valid_o`=0.
  - `kl`=1: pop and discard with no output; clear both bits for that id.
  - `cm`=1: `result_valid_o`=1. Pop when `result_ready_i`=1, then clear both bits.
  - Neither set: wait, with `result_valid_o`=0.
- If a commit for an id arrives in the same cycle its bits are cleared by a pop, the clear wins. This cannot occur for a legal CPU, because ids are not reused before retirement.
- Commit may arrive before, with, or after the ALU result for the same id. All three orders must work.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- `rst_i`: count=0, pointers=0, all table bits=0, `overflow_o`=0. FIFO data contents are don't-care.
- Reset mid-operation: all buffered results and pending commits are lost; no result is emitted after reset.

## Timing
- Reset values:
  - `alu_ready_o`=1
  - `result_valid_o`=0
  - `overflow_o`=0
  - result fields = 0 (head RAM is forced to 0 via the empty mux).
- `alu_ready_o` = (count != Depth), decoded from registered count. It is not asserted early on a same-cycle pop.
- Latency:
  - ALU push at cycle N, commit already recorded → `result_valid_o` at N+1.
  - Commit at cycle N for an id already at head → `result_valid_o` at N+1.
  - Kill at N for head id → discard at N+1, next head evaluated at N+2.
- Throughput: one result per cycle when committed and `result_ready_i`=1. Each killed entry costs one cycle.
- Handshake: once `result_valid_o`=1, the valid and all result fields stay stable until `result_ready_i`=1. Valid never drops without a transfer, except on reset.
- Results leave in ALU order. Killed entries never appear on the result port.

## Test plan
- Commit-first: commit id=3 at cycle 0, ALU push id=3 data=0xDEADBEEF rd=5 we=1 at cycle 2, `result_ready_i`=1 → `result_valid_o` at cycle 3 with data 0xDEADBEEF, rd 5; FIFO empty at cycle 4.
- Result-first with back-pressure:
  - Push id=1, commit id=1 at cycle 3, `result_ready_i`=0 until cycle 7.
  - Required: valid high from cycle 4, fields stable through cycle 7, transfer at cycle 7, valid low at cycle 8.
- Kill: push ids 0,1,2 with commits {0:commit, 1:kill, 2:commit} and ready=1 → only ids 0 and 2 appear on the result port, in order; table bits for id 1 are cleared.
- Full/overflow (Depth=4):
  - Push 4 entries with no commits → `alu_ready_o`=0.
  - A 5th push → `overflow_o`=1, count stays 4.
  - Commit all four → four results emitted, then `alu_ready_o`=1.
- Simultaneous push/pop: steady stream of committed results with ready=1, one push per cycle for 16 cycles → one result per cycle, count constant at 1, pointers wrap correctly.
- Reset mid-operation: 3 entries buffered, 2 committed, `rst_i` for one cycle → `result_valid_o`=0, `alu_ready_o`=1. A later push of id=0 without a commit produces no result.
